spio_hss_multiplexer_tx_scheduler: RTL
======================================

# spio_hss_multiplexer_tx_scheduler

Credit-based round-robin scheduler that decides which of the eight TX packet streams the HSS multiplexer frames next. Sits between the eight per-channel TX packet buffers and the frame assembler in `spio_hss_multiplexer`. Each channel holds remote-buffer credits returned by the receive side. Grants are offered one at a time via a valid/ready handshake, and only while the link handshake is complete.

## Interface
Parameters:
- `NUM_CHANNELS`, 8: number of packet streams (fixed at 8 in this design).
- `CHAN_BITS`, 3: width of the channel index.
- `CREDIT_BITS`, 4: width of each per-channel credit counter.
- `INIT_CREDITS`, 8: credits loaded per channel at reset and on link loss; must be at most 2^`CREDIT_BITS`-1.

Ports:
- `CLK_IN`  in  1  serial-interface word clock; the only clock.
- `RESET_IN`  in  1  reset, synchronous, active-high.
- `HANDSHAKE_COMPLETE_IN`  in  1  link up, from rx_control.
- `REQ_IN`  in  8  bit i high: channel i has a packet pending; held until granted.
- `CREDIT_RET_IN`  in  8  bit i high: one credit returned to channel i this cycle.
- `SLOT_RDY_IN`  in  1  frame assembler accepts the offered grant this cycle.
- `GRANT_VLD_OUT`  out  1  a grant is on offer.
- `GRANT_ID_OUT`  out  3  index of the granted channel.
- `GRANT_OUT`  out  8  one-hot copy of `GRANT_ID_OUT`; all zero when not valid.
- `CREDITS_ZERO_OUT`  out  8  bit i high: channel i has no credits.
- `CREDIT_OVF_OUT`  out  1  sticky flag: a credit was returned to a full counter.

## Operation
- Eligibility: `elig[i] = REQ_IN[i] & (credit[i] != 0)`.
- Two states:
  - IDLE: `GRANT_VLD_OUT`=0.
  - OFFER: `GRANT_VLD_OUT`=1.
- IDLE -> OFFER when `HANDSHAKE_COMPLETE_IN` and any `elig`. The offer loads the winner of a rotating-priority search starting at `last_id+1` and wrapping from 7 to 0.
- In OFFER, `GRANT_ID_OUT` and `GRANT_OUT` stay stable until accepted. Acceptance is `GRANT_VLD_OUT & SLOT_RDY_IN`.
- On accept:
  - `credit[id]` decrements.
  - `last_id` takes the value of `id`.
  - The next winner is searched using the post-update credits and eligibility, excluding nothing but starting at `id+1`.
  - If an eligible channel exists, stay in OFFER with the new id. Otherwise go to IDLE.
- Credit update per channel per cycle is `credit + ret - take`. Simultaneous return and take on the same channel leaves the credit unchanged.
- Return to a counter at 2^`CREDIT_BITS`-1 with no take: the counter saturates and `CREDIT_OVF_OUT` is set.
- `HANDSHAKE_COMPLETE_IN` low, in any state:
  - Next cycle: state IDLE and all credits = `INIT_CREDITS`.
  - `CREDIT_OVF_OUT` cleared; `last_id` = 7, so channel 0 has first priority.
  - Returns and `SLOT_RDY_IN` are ignored.
- Deasserting `REQ_IN` while offered is a protocol violation. The offer is still held; the bench must not do this.

## Timing
- All outputs registered.
- Reset values:
  - `GRANT_VLD_OUT`=0, `GRANT_ID_OUT`=0, `GRANT_OUT`=0.
  - `CREDITS_ZERO_OUT`=0 (with `INIT_CREDITS` nonzero), `CREDIT_OVF_OUT`=0.
  - All credits = `INIT_CREDITS`, `last_id`=7.
- Latency:
  - `REQ_IN` rising at cycle N (credits available, link up) gives `GRANT_VLD_OUT` at N+1.
  - Back-to-back accepts sustain one grant per cycle.
- Credit effect: a credit returned at cycle N makes the channel eligible at N+1, giving a grant at N+2 from IDLE. `CREDITS_ZERO_OUT` reflects credits after the edge.
- Reset takes priority over the link-down behaviour, which takes priority over all other updates.

## Structure
- Shared constants go in `spio_hss_multiplexer_common.h`: `NUM_CHANNELS`, `CHAN_BITS`, `INIT_CREDITS`, `CREDIT_BITS`.
- One combinational sub-module, `spio_hss_multiplexer_rr_pick`: 8-bit eligibility plus start index in, found flag plus 3-bit winner out.
- Credit counters and the state machine live in the top of this block.

## Test plan
- Reset, link up, `REQ_IN`=8'h01 at cycle N, `SLOT_RDY_IN`=1 -> grant id 0 at N+1. Channel 0 gets 8 grants in total, then `CREDITS_ZERO_OUT[0]`=1 and `GRANT_VLD_OUT`=0.
- `REQ_IN`=8'hFF, `SLOT_RDY_IN`=1 always -> ids 0,1,…,7,0 on consecutive cycles with no bubbles.
- `REQ_IN`=8'h24 (channels 2 and 5), `SLOT_RDY_IN` low for 5 cycles -> id 2 held stable. Then ready high -> 2, 5, 2, 5…
- Channel 3 at 0 credits with `REQ_IN[3]`=1; pulse `CREDIT_RET_IN[3]` at N -> `CREDITS_ZERO_OUT[3]` low at N+1, grant id 3 at N+2.
- Accept and return on channel 1 in the same cycle -> credit unchanged. 8 returns to a full counter (15) -> stays 15 and `CREDIT_OVF_OUT`=1.
- Drop `HANDSHAKE_COMPLETE_IN` mid-offer -> `GRANT_VLD_OUT`=0 next cycle, credits all 8, overflow flag cleared. Relink with 8'hFF -> first grant id 0.

Source files
------------

// File: rtl/spio_hss_multiplexer_tx_scheduler_pkg.sv
// Shared constants, state type and helpers for the HSS multiplexer TX scheduler.
package spio_hss_multiplexer_tx_scheduler_pkg;

   localparam int NUM_CHANNELS = 8;
   localparam int CHAN_BITS    = 3;
   localparam int CREDIT_BITS  = 4;
   localparam int INIT_CREDITS = 8;

   typedef enum logic {
      SCHED_IDLE  = 1'b0,
      SCHED_OFFER = 1'b1
   } sched_state_t;

   // One-hot decode of a channel index.
   function automatic logic [NUM_CHANNELS-1:0] chan_onehot(input logic [CHAN_BITS-1:0] id);
      logic [NUM_CHANNELS-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/spio_hss_multiplexer_rr_pick.sv
// Rotating-priority search: first eligible channel at or after 'start', wrapping 7 -> 0.
module spio_hss_multiplexer_rr_pick
   import spio_hss_multiplexer_tx_scheduler_pkg::*;
(
   input  logic [NUM_CHANNELS-1:0] elig,
   input  logic [CHAN_BITS-1:0]    start,
   output logic                    found,
   output logic [CHAN_BITS-1:0]    winner
);

   logic [CHAN_BITS-1:0] idx;

   // Walk the channels from 'start' and keep the first eligible one.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = start + CHAN_BITS'(k);
         if (!found && elig[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/spio_hss_multiplexer_tx_scheduler.sv
// Credit-based round-robin scheduler choosing the next TX channel to frame.
module spio_hss_multiplexer_tx_scheduler #(
   parameter int NUM_CHANNELS = spio_hss_multiplexer_tx_scheduler_pkg::NUM_CHANNELS,
   parameter int CHAN_BITS    = spio_hss_multiplexer_tx_scheduler_pkg::CHAN_BITS,
   parameter int CREDIT_BITS  = spio_hss_multiplexer_tx_scheduler_pkg::CREDIT_BITS,
   parameter int INIT_CREDITS = spio_hss_multiplexer_tx_scheduler_pkg::INIT_CREDITS
) (
   input  logic                    CLK_IN,
   input  logic                    RESET_IN,
   input  logic                    HANDSHAKE_COMPLETE_IN,
   input  logic [NUM_CHANNELS-1:0] REQ_IN,
   input  logic [NUM_CHANNELS-1:0] CREDIT_RET_IN,
   input  logic                    SLOT_RDY_IN,
   output logic                    GRANT_VLD_OUT,
   output logic [CHAN_BITS-1:0]    GRANT_ID_OUT,
   output logic [NUM_CHANNELS-1:0] GRANT_OUT,
   output logic [NUM_CHANNELS-1:0] CREDITS_ZERO_OUT,
   output logic                    CREDIT_OVF_OUT
);

   import spio_hss_multiplexer_tx_scheduler_pkg::*;

   localparam logic [CREDIT_BITS-1:0] CREDIT_MAX  = '1;
   localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(INIT_CREDITS);

   sched_state_t state, state_next;

   logic [CREDIT_BITS-1:0]  credit      [NUM_CHANNELS];
   logic [CREDIT_BITS-1:0]  credit_next [NUM_CHANNELS];
   logic [CHAN_BITS-1:0]    grant_id, grant_id_next;
   logic [CHAN_BITS-1:0]    last_id, last_id_next;
   logic [NUM_CHANNELS-1:0] grant_onehot;
   logic                    ovf, ovf_next;
   logic                    accept;
   logic [NUM_CHANNELS-1:0] take, elig_cur, elig_post, pick_elig;
   logic [CHAN_BITS-1:0]    pick_start, pick_winner;
   logic                    pick_found;
   logic                    link_reset;

   assign link_reset = RESET_IN || !HANDSHAKE_COMPLETE_IN;
   assign accept     = (state == SCHED_OFFER) && SLOT_RDY_IN;

   // From IDLE the search uses the credits as they stand; after an accept it
   // uses the credits as they will be once this cycle's take/return land.
   assign pick_elig  = (state == SCHED_OFFER) ? elig_post : elig_cur;
   assign pick_start = ((state == SCHED_OFFER) ? grant_id : last_id) + CHAN_BITS'(1);

   spio_hss_multiplexer_rr_pick u_rr_pick (
      .elig   (pick_elig),
      .start  (pick_start),
      .found  (pick_found),
      .winner (pick_winner)
   );

   // Per-channel credit arithmetic: return adds, accepted grant takes, full counter saturates.
   always_comb begin
      ovf_next  = ovf;
      take      = '0;
      elig_cur  = '0;
      elig_post = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         credit_next[i] = credit[i];
         take[i]        = accept && (grant_id == CHAN_BITS'(i));
         if (CREDIT_RET_IN[i] && !take[i]) begin
            if (credit[i] == CREDIT_MAX) begin
               ovf_next = 1'b1;
            end else begin
               credit_next[i] = credit[i] + CREDIT_BITS'(1);
            end
         end else if (take[i] && !CREDIT_RET_IN[i]) begin
            credit_next[i] = credit[i] - CREDIT_BITS'(1);
         end
         elig_cur[i]  = REQ_IN[i] && (credit[i] != '0);
         elig_post[i] = REQ_IN[i] && (credit_next[i] != '0);
      end
   end

   // Next-state logic: open an offer from IDLE, roll to the next winner on accept.
   always_comb begin
      state_next    = state;
      grant_id_next = grant_id;
      last_id_next  = last_id;
      case (state)
         SCHED_IDLE: begin
            if (pick_found) begin
               state_next    = SCHED_OFFER;
               grant_id_next = pick_winner;
            end
         end
         SCHED_OFFER: begin
            if (accept) begin
               last_id_next = grant_id;
               if (pick_found) begin
                  grant_id_next = pick_winner;
               end else begin
                  state_next = SCHED_IDLE;
               end
            end
         end
         default: state_next = SCHED_IDLE;
      endcase
   end

   // State and grant registers; losing the link behaves like a reset.
   always_ff @(posedge CLK_IN) begin
      if (link_reset) begin
         state        <= SCHED_IDLE;
         grant_id     <= '0;
         last_id      <= '1;
         grant_onehot <= '0;
      end else begin
         state        <= state_next;
         grant_id     <= grant_id_next;
         last_id      <= last_id_next;
         grant_onehot <= (state_next == SCHED_OFFER) ? chan_onehot(grant_id_next) : '0;
      end
   end

   // Credit counters and the sticky overflow flag.
   always_ff @(posedge CLK_IN) begin
      if (link_reset) begin
         ovf <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            credit[i] <= CREDIT_INIT;
         end
      end else begin
         ovf <= ovf_next;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            credit[i] <= credit_next[i];
         end
      end
   end

   // Zero-credit flags decoded straight from the credit registers.
   always_comb begin
      CREDITS_ZERO_OUT = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         CREDITS_ZERO_OUT[i] = (credit[i] == '0);
      end
   end

   assign GRANT_VLD_OUT  = (state == SCHED_OFFER);
   assign GRANT_ID_OUT   = grant_id;
   assign GRANT_OUT      = grant_onehot;
   assign CREDIT_OVF_OUT = ovf;

endmodule
